// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle RV32I-subset control sequencer
//
// Steps each instruction through fetch, decode, execute, memory and write-back
// using one shared ALU and one unified memory port. Handshakes with memory via
// memReady, traps on illegal opcodes/funct3 and on memory wait overruns, and
// counts retired instructions.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-low reset
//   instruction         current IR contents
//   zero                ALU zero flag (branch compare)
//   memReady            memory completes the current access this cycle
//   pcWrite, oldPcWrite, irWrite, iorD, memRead, memWrite, memtoReg,
//   regWrite, aluSrcA, aluSrcB, aluOp, pcSource
//                       datapath enables and mux selects (decoded from state)
//   illegal, timeout    sticky trap causes
//   state               current state encoding (debug)
//   instret             retired instruction count, wraps modulo 2^32
module multi_cycle_control #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        memReady,
  output logic        pcWrite,
  output logic        oldPcWrite,
  output logic        irWrite,
  output logic        iorD,
  output logic        memRead,
  output logic        memWrite,
  output logic        memtoReg,
  output logic        regWrite,
  output logic [1:0]  aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  aluOp,
  output logic        pcSource,
  output logic        illegal,
  output logic        timeout,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  localparam int WCNT_W = ($clog2(MEM_WAIT_MAX + 1) > 4) ? $clog2(MEM_WAIT_MAX + 1) : 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    MEM_ADDR  = 4'd4,
    MEM_READ  = 4'd5,
    MEM_WRITE = 4'd6,
    WB_ALU    = 4'd7,
    WB_MEM    = 4'd8,
    BRANCH    = 4'd9,
    TRAP      = 4'd10
  } state_t;

  state_t             cur;
  logic [WCNT_W-1:0]  wait_cnt;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               mem_state;
  logic               wait_expired;
  logic               branch_ok;
  logic               retire;
  logic               unused_bits;

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign unused_bits = ^{instruction[31:15], instruction[11:7]};
  assign state       = cur;

  // States that wait on memReady share one wait counter.
  assign mem_state = (cur == FETCH) || (cur == MEM_READ) || (cur == MEM_WRITE);

  // The count would reach MEM_WAIT_MAX on this edge; a simultaneous memReady
  // still completes the access because memReady is checked first below.
  assign wait_expired = mem_state && !memReady &&
                        (wait_cnt == WCNT_W'(MEM_WAIT_MAX - 1));

  assign branch_ok = (funct3 == 3'b000) || (funct3 == 3'b001);

  assign retire = (cur == WB_ALU) || (cur == WB_MEM) ||
                  ((cur == MEM_WRITE) && memReady) ||
                  ((cur == BRANCH) && branch_ok);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur      <= FETCH;
      wait_cnt <= '0;
      instret  <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (retire) begin
        instret <= instret + 32'd1;
      end
      // Any transition clears the wait counter; only a stalled memory state
      // overrides this with an increment.
      wait_cnt <= '0;
      case (cur)
        FETCH, MEM_READ, MEM_WRITE: begin
          if (memReady) begin
            case (cur)
              FETCH:    cur <= DECODE;
              MEM_READ: cur <= WB_MEM;
              default:  cur <= FETCH;
            endcase
          end else if (wait_expired) begin
            cur     <= TRAP;
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DECODE: begin
          case (opcode)
            OP_R:               cur <= EXEC_R;
            OP_I:               cur <= EXEC_I;
            OP_LOAD, OP_STORE:  cur <= MEM_ADDR;
            OP_BRANCH:          cur <= BRANCH;
            default: begin
              cur     <= TRAP;
              illegal <= 1'b1;
            end
          endcase
        end
        EXEC_R, EXEC_I: cur <= WB_ALU;
        MEM_ADDR:       cur <= (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
        WB_ALU, WB_MEM: cur <= FETCH;
        BRANCH: begin
          if (branch_ok) begin
            cur <= FETCH;
          end else begin
            cur     <= TRAP;
            illegal <= 1'b1;
          end
        end
        TRAP:    cur <= TRAP;
        default: cur <= TRAP;
      endcase
    end
  end

  // Datapath controls are decoded from the current state; FETCH and BRANCH
  // additionally depend on memReady / zero within the cycle.
  always_comb begin
    pcWrite    = 1'b0;
    oldPcWrite = 1'b0;
    irWrite    = 1'b0;
    iorD       = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    memtoReg   = 1'b0;
    regWrite   = 1'b0;
    aluSrcA    = 2'b00;
    aluSrcB    = 2'b00;
    aluOp      = 2'b00;
    pcSource   = 1'b0;
    case (cur)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        if (memReady) begin
          irWrite    = 1'b1;
          pcWrite    = 1'b1;
          oldPcWrite = 1'b1;
        end
      end
      DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
      end
      EXEC_R: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b00;
        aluOp   = 2'b10;
      end
      EXEC_I: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b10;
        aluOp   = 2'b11;
      end
      MEM_ADDR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b10;
      end
      MEM_READ: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      MEM_WRITE: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      WB_ALU: begin
        regWrite = 1'b1;
      end
      WB_MEM: begin
        regWrite = 1'b1;
        memtoReg = 1'b1;
      end
      BRANCH: begin
        aluSrcA  = 2'b10;
        aluOp    = 2'b01;
        pcSource = 1'b1;
        if (funct3 == 3'b000) begin
          pcWrite = zero;
        end else if (funct3 == 3'b001) begin
          pcWrite = !zero;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle sequencer for the RV32I-subset datapath: replaces single-cycle decode with a Moore/Mealy FSM that steps each instruction through fetch, decode, execute, memory and write-back. It shares one ALU and one unified memory port across phases. It handshakes with memory (`memReady`), detects illegal opcodes and memory timeouts, and counts retired instructions. It sits between the instruction register (IR) and the datapath muxes and enables.

## Interface
- `MEM_WAIT_MAX`, default 15: maximum cycles spent waiting for `memReady` in one memory state before trapping.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-low reset.
- `instruction` input 32: current IR contents.
- `zero` input 1: ALU zero flag.
- `memReady` input 1: memory completes the current access this cycle.
- `pcWrite` output 1: PC load enable.
- `oldPcWrite` output 1: saves the current PC into the oldPC register.
- `irWrite` output 1: IR load enable.
- `iorD` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `memRead` output 1: memory read request.
- `memWrite` output 1: memory write request.
- `memtoReg` output 1: write-back select; 0 = ALUOut, 1 = MDR.
- `regWrite` output 1: register file write enable.
- `aluSrcA` output 2: 00 = PC, 01 = oldPC, 10 = regA.
- `aluSrcB` output 2: 00 = regB, 01 = constant 4, 10 = immediate.
- `aluOp` output 2: 00 = add, 01 = sub, 10 = R-type funct decode, 11 = I-type funct decode.
- `pcSource` output 1: 0 = ALU result, 1 = ALUOut.
- `illegal` output 1: sticky; trapped on a bad opcode or funct3.
- `timeout` output 1: sticky; trapped on a memory wait overrun.
- `state` output 4: current state encoding, for debug.
- `instret` output 32: count of retired instructions.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_READ=5, MEM_WRITE=6, WB_ALU=7, WB_MEM=8, BRANCH=9, TRAP=10.
- All outputs are 0 in every state unless listed below.
- **FETCH**
  - Drives `memRead`=1, `iorD`=0, `aluSrcA`=00, `aluSrcB`=01, `aluOp`=00.
  - When `memReady`=1 it also drives `irWrite`=1, `pcWrite`=1, `oldPcWrite`=1 (Mealy) and moves to DECODE.
- **DECODE**
  - Drives `aluSrcA`=01, `aluSrcB`=10, `aluOp`=00, computing the branch target into ALUOut.
  - Next state is chosen on `instruction[6:0]`:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → MEM_ADDR
    - 1100011 → BRANCH
    - anything else → TRAP with `illegal` set.
- **EXEC_R**: `aluSrcA`=10, `aluSrcB`=00, `aluOp`=10, then → WB_ALU.
- **EXEC_I**: `aluSrcA`=10, `aluSrcB`=10, `aluOp`=11, then → WB_ALU.
- **MEM_ADDR**: `aluSrcA`=10, `aluSrcB`=10, `aluOp`=00. Goes → MEM_READ if the opcode is 0000011, else → MEM_WRITE.
- **MEM_READ**: `memRead`=1, `iorD`=1. On `memReady` → WB_MEM.
- **MEM_WRITE**: `memWrite`=1, `iorD`=1. On `memReady` the instruction retires and the FSM returns to FETCH.
- **WB_ALU**: `regWrite`=1, `memtoReg`=0. Retires, → FETCH.
- **WB_MEM**: `regWrite`=1, `memtoReg`=1. Retires, → FETCH.
- **BRANCH**
  - Drives `aluSrcA`=10, `aluSrcB`=00, `aluOp`=01, `pcSource`=1.
  - funct3=000: `pcWrite` = `zero`.
  - funct3=001: `pcWrite` = !`zero`.
  - Either of these retires the instruction and → FETCH.
  - Any other funct3 → TRAP with `illegal` set, no `pcWrite`, no retire.
- **TRAP**: absorbing. All enables are 0. Only reset leaves it.
- **Wait counter**
  - 4+ bits wide. Cleared on entry to FETCH, MEM_READ or MEM_WRITE; increments each cycle `memReady`=0 in those states.
  - When it reaches `MEM_WAIT_MAX` with `memReady` still 0, the FSM goes → TRAP with `timeout` set.
  - If `memReady`=1 on that same cycle, the access completes normally.
- **instret**: +1 on each retiring clock edge, wrapping modulo 2^32 (0xFFFFFFFF → 0).

## Timing
- Reset with `reset`=0 sampled on a rising edge:
  - Next cycle `state`=FETCH, `instret`=0, `illegal`=0, `timeout`=0, wait counter = 0.
  - The combinational outputs then show FETCH values (`memRead`=1).
- Reset mid-access aborts the access. Memory must accept a restarted fetch the next cycle. Reset overrides TRAP.
- `instruction` must be stable from the cycle after `irWrite` until the next FETCH.
- Latency with zero-wait memory (`memReady` tied to 1), counted from FETCH entry to the next FETCH entry:
  - R-type and I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- Memory requests (`memRead`/`memWrite`) are held constant while waiting and drop in the cycle after `memReady`.

## Test plan
- **Reset**: hold `reset`=0 for 2 cycles, then release. Expect `state`=0, `memRead`=1, `instret`=0, `illegal`=0, `timeout`=0.
- **Zero-wait sequence**: `memReady`=1 throughout; feed `add` (0x002081B3), `lw` (0x0000A183), `sw` (0x0030A023). Expect `state` sequences 0,1,2,7 / 0,1,4,5,8 / 0,1,4,6, `instret` 0→3 after 13 cycles, and `regWrite` pulsed exactly twice.
- **Branches**: `beq` (funct3=000) with `zero`=1 → `pcWrite`=1 and `pcSource`=1 in BRANCH. Same with `zero`=0 → `pcWrite`=0. `bne` with `zero`=0 → `pcWrite`=1. All three increment `instret`.
- **Wait states**: `memReady` low for 3 cycles during MEM_READ → FSM stays in state 5 for 4 cycles with `memRead`=1 and `iorD`=1, then goes to WB_MEM.
- **Timeout**: `MEM_WAIT_MAX`=4, `memReady` held 0 in FETCH → `state`=10 and `timeout`=1 after 4 cycles. Then `reset`=0 → back to FETCH with `timeout`=0.
- **Illegal**:
  - Opcode 0x7F → TRAP after DECODE, `illegal`=1, enables stay 0 for 10+ cycles, `instret` unchanged.
  - A branch with funct3=010 → same response.
